pipelined_mul_unit: RTL and testbench

Parametrised M-extension multiply unit for the execute stage. It replaces the fixed five-stage artificial multiplier with a configurable-depth pipeline. New over the old unit:
- all four RV32M multiply ops
- per-stage valid bits
- writeback back-pressure with a stall output to the issue logic
- pipeline flush
- a destination-register busy mask for hazard detection

---
 rtl/pipelined_mul_unit.sv | 138 +++++++++++++
 tb/tb_pipelined_mul_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_mul_unit
//  Purpose  : RV32M multiply unit (MUL/MULH/MULHSU/MULHU) for the execute
//             stage. The product is formed combinationally from the inputs and
//             registered into slot S1. It is then carried through STAGES slots
//             in total. The unit has valid/ready flow control, flush, and a
//             destination-register busy mask for hazard detection.
//  Ports    : clk, rst (sync, active-high), flush
//             in_valid/in_ready, in_op, in_src1, in_src2, in_rd, in_tag
//             stall_mul_out (= !in_ready)
//             out_valid/out_ready, out_data, out_rd, out_tag
//             rd_busy[31:0] (bit r set while a live slot targets x_r, r != 0)
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_mul_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 5,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [4:0]       in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             stall_mul_out,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_rd,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic [31:0]      rd_busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam int         PW        = 2*XLEN + 2;

  // Pipeline slots; index 0 is S1, index STAGES-1 drives the outputs.
  logic             valid_q [STAGES];
  logic [4:0]       rd_q    [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [XLEN-1:0]  data_q  [STAGES];

  logic             adv;
  logic             accept;
  logic             a_sign;
  logic             b_sign;
  logic [PW-1:0]    a_wide;
  logic [PW-1:0]    b_wide;
  logic [PW-1:0]    prod;
  logic [XLEN-1:0]  s1_data_d;
  logic             unused_prod_hi;

  // The whole pipe moves as a unit. It stalls only when a result sits at the
  // output and writeback is not taking it.
  assign adv           = !out_valid || out_ready;
  assign in_ready      = adv && !flush && !rst;
  assign stall_mul_out = !in_ready;
  assign accept        = in_valid && in_ready;

  // Each operand is extended by one sign-or-zero bit, which gives XLEN+1 bits.
  // It is then sign-extended to the full product width. The low PW bits of
  // the unsigned product of these values equal the signed product of the
  // (XLEN+1)-bit operands, so one multiplier covers all four ops.
  always_comb begin
    a_sign = 1'b0;
    b_sign = 1'b0;
    case (in_op)
      OP_MULH: begin
        a_sign = in_src1[XLEN-1];
        b_sign = in_src2[XLEN-1];
      end
      OP_MULHSU: a_sign = in_src1[XLEN-1];
      default: begin
      end
    endcase
  end

  assign a_wide         = {{(XLEN+1){a_sign}}, a_sign, in_src1};
  assign b_wide         = {{(XLEN+1){b_sign}}, b_sign, in_src2};
  assign prod           = a_wide * b_wide;
  assign s1_data_d      = (in_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod_hi = ^prod[PW-1:2*XLEN];

  // Flush clears only the valid bits. The payload of a dead slot is never
  // observed, so it is left as it is.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        tag_q[k]   <= '0;
        data_q[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
      end
    end else if (adv) begin
      valid_q[0] <= accept;
      if (accept) begin
        rd_q[0]   <= in_rd;
        tag_q[0]  <= in_tag;
        data_q[0] <= s1_data_d;
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        tag_q[k]   <= tag_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_rd    = rd_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  // x0 is never a hazard, so bit 0 stays clear even for live rd==0 ops.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && (rd_q[k] != 5'd0)) begin
        rd_busy[rd_q[k]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_mul_unit
//  Purpose  : Self-checking bench for pipelined_mul_unit. It uses directed
//             scenarios plus randomized traffic, checked against a
//             queue-based arithmetic reference model. Extra instances with
//             STAGES=1 and STAGES=8 share the main stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_mul_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_rd;
  logic [3:0]  in_tag;

  logic        in_ready, stall_mul_out, out_valid;
  logic [31:0] out_data, rd_busy;
  logic [4:0]  out_rd;
  logic [3:0]  out_tag;

  logic        s1_in_ready, s1_stall, s1_out_valid;
  logic [31:0] s1_out_data, s1_rd_busy;
  logic [4:0]  s1_out_rd;
  logic [3:0]  s1_out_tag;

  logic        s8_in_ready, s8_stall, s8_out_valid;
  logic [31:0] s8_out_data, s8_rd_busy;
  logic [4:0]  s8_out_rd;
  logic [3:0]  s8_out_tag;

  pipelined_mul_unit #(.XLEN(32), .STAGES(5), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_tag(in_tag),
    .in_ready(in_ready), .stall_mul_out(stall_mul_out), .out_valid(out_valid),
    .out_data(out_data), .out_rd(out_rd), .out_tag(out_tag),
    .out_ready(out_ready), .rd_busy(rd_busy));

  pipelined_mul_unit #(.XLEN(32), .STAGES(1), .TAG_W(4)) u_dut_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_tag(in_tag),
    .in_ready(s1_in_ready), .stall_mul_out(s1_stall), .out_valid(s1_out_valid),
    .out_data(s1_out_data), .out_rd(s1_out_rd), .out_tag(s1_out_tag),
    .out_ready(out_ready), .rd_busy(s1_rd_busy));

  pipelined_mul_unit #(.XLEN(32), .STAGES(8), .TAG_W(4)) u_dut_s8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_tag(in_tag),
    .in_ready(s8_in_ready), .stall_mul_out(s8_stall), .out_valid(s8_out_valid),
    .out_data(s8_out_data), .out_rd(s8_out_rd), .out_tag(s8_out_tag),
    .out_ready(out_ready), .rd_busy(s8_rd_busy));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference arithmetic: the exact 64-bit product with the operand
  // signedness each op defines.
  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b01:   p = 64'(longint'($signed(a)) * longint'($signed(b)));
      2'b10:   p = 64'(longint'($signed(a)) * longint'({32'h0, b}));
      default: p = {32'h0, a} * {32'h0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Busy mask implied by the set of ops still owed to writeback.
  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (exp_q[i]) if (exp_q[i].rd != 5'd0) b[exp_q[i].rd] = 1'b1;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_src1 = '0; in_src2 = '0; in_rd = '0; in_tag = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle(); out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_rd !== 5'h0) begin errors++; $display("FAIL reset_out_rd got=%h exp=0", out_rd); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (rd_busy !== 32'h0) begin errors++; $display("FAIL reset_rd_busy got=%h exp=0", rd_busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
    checks++; if (stall_mul_out !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", stall_mul_out); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    step();
  endtask

  task automatic test_basic_ops();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF_FFFE; exp_tab[1] = 32'hFFFF_FFFF;
    exp_tab[2] = 32'hFFFF_FFFF; exp_tab[3] = 32'h0000_0001;
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      in_valid = 1'b1; in_op = 2'(op); in_src1 = 32'hFFFF_FFFF; in_src2 = 32'h2;
      in_rd = 5'(op + 1); in_tag = 4'(op);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready op=%0d got=%b exp=1", op, in_ready); end
      step();
      set_idle();
      for (int k = 1; k <= 5; k++) begin
        #1;
        if (k < 5) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid op=%0d k=%0d got=%b exp=0", op, k, out_valid); end
          step();
        end else begin
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid op=%0d got=%b exp=1", op, out_valid); end
          checks++; if (out_data !== exp_tab[op]) begin errors++; $display("FAIL basic_data op=%0d got=%h exp=%h", op, out_data, exp_tab[op]); end
          checks++; if (out_rd !== 5'(op + 1)) begin errors++; $display("FAIL basic_rd op=%0d got=%0d exp=%0d", op, out_rd, op + 1); end
        end
      end
      step();
    end
  endtask

  task automatic test_streaming();
    int i;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        in_valid = 1'b1; in_op = 2'b00; in_src1 = 32'(cyc); in_src2 = 32'(cyc + 1);
        in_tag = 4'(cyc); in_rd = 5'd3;
      end else begin
        set_idle();
      end
      #1;
      if (cyc >= 5 && cyc < 13) begin
        i = cyc - 5;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, out_valid); end
        checks++; if (out_data !== 32'(i * (i + 1))) begin errors++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, out_data, 32'(i * (i + 1))); end
        checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL stream_tag i=%0d got=%0d exp=%0d", i, out_tag, i); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid cyc=%0d got=%b exp=0", cyc, out_valid); end
      end
      step();
    end
  endtask

  task automatic test_back_pressure();
    logic [1:0]  ops [6];
    logic [31:0] as [6], bs [6];
    logic [4:0]  rds [6];
    int issued, got, bp_left;
    logic seen, hold_chk, acc, cons;
    logic [31:0] h_data; logic [4:0] h_rd; logic [3:0] h_tag;
    exp_t e, f;
    for (int n = 0; n < 6; n++) begin
      ops[n] = 2'($urandom_range(0, 3)); as[n] = $urandom; bs[n] = $urandom;
      rds[n] = 5'($urandom_range(1, 31));
    end
    exp_q.delete();
    issued = 0; got = 0; bp_left = 0; seen = 1'b0; hold_chk = 1'b0;
    h_data = '0; h_rd = '0; h_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (issued < 6) begin
        in_valid = 1'b1; in_op = ops[issued]; in_src1 = as[issued]; in_src2 = bs[issued];
        in_rd = rds[issued]; in_tag = 4'(issued);
      end else begin
        set_idle();
      end
      if (out_valid && !seen) begin seen = 1'b1; bp_left = 3; end
      out_ready = (bp_left == 0);
      #1;
      if (hold_chk) begin
        checks++; if (out_valid !== 1'b1 || out_data !== h_data || out_rd !== h_rd || out_tag !== h_tag) begin
          errors++; $display("FAIL bp_hold got=%b/%h/%0d/%0d exp=1/%h/%0d/%0d", out_valid, out_data, out_rd, out_tag, h_data, h_rd, h_tag);
        end
      end
      if (bp_left > 0) begin
        checks++; if (stall_mul_out !== 1'b1) begin errors++; $display("FAIL bp_stall left=%0d got=%b exp=1", bp_left, stall_mul_out); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready left=%0d got=%b exp=0", bp_left, in_ready); end
        bp_left--;
      end
      hold_chk = out_valid && !out_ready;
      h_data = out_data; h_rd = out_rd; h_tag = out_tag;
      cons = out_valid && out_ready;
      if (cons) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_result got=%h exp=none", out_data);
        end else begin
          f = exp_q.pop_front();
          if (out_data !== f.data || out_rd !== f.rd || out_tag !== f.tag) begin
            errors++; $display("FAIL bp_result got=%h/%0d/%0d exp=%h/%0d/%0d", out_data, out_rd, out_tag, f.data, f.rd, f.tag);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        e.data = ref_mul(ops[issued], as[issued], bs[issued]); e.rd = rds[issued]; e.tag = 4'(issued);
        exp_q.push_back(e); issued++;
      end
    end
    set_idle(); out_ready = 1'b1;
    checks++; if (got != 6 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count got=%0d exp=6 (left=%0d)", got, exp_q.size()); end
    step();
  endtask

  task automatic test_flush();
    logic [4:0] rds [3];
    int seen_valid;
    rds[0] = 5'd5; rds[1] = 5'd7; rds[2] = 5'd0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      set_idle();
      if (cyc < 3) begin
        in_valid = 1'b1; in_rd = rds[cyc]; in_src1 = 32'(cyc + 3); in_src2 = 32'h11; in_tag = 4'(cyc);
      end
      if (cyc == 4) begin
        flush = 1'b1; in_valid = 1'b1; in_rd = 5'd9; in_src1 = 32'h5; in_src2 = 32'h6;
      end
      #1;
      if (cyc >= 3) begin
        checks++; if (rd_busy !== 32'h0000_00A0) begin errors++; $display("FAIL flush_pre_busy cyc=%0d got=%h exp=000000a0", cyc, rd_busy); end
      end
      if (cyc == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
      end
      step();
    end
    set_idle();
    #1;
    checks++; if (rd_busy !== 32'h0) begin errors++; $display("FAIL flush_post_busy got=%h exp=0", rd_busy); end
    seen_valid = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) seen_valid++;
      step();
    end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL flush_leak got=%0d valid cycles exp=0", seen_valid); end
  endtask

  task automatic test_random();
    logic acc, cons, fl;
    exp_t e, f;
    exp_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_op = 2'($urandom_range(0, 3)); in_src1 = $urandom; in_src2 = $urandom;
      in_rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      in_tag = 4'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      checks++; if (stall_mul_out !== !in_ready) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall_mul_out, !in_ready); end
      checks++; if (rd_busy !== model_busy()) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, rd_busy, model_busy()); end
      if (flush) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_flush_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, out_data);
        end else if (out_data !== exp_q[0].data || out_rd !== exp_q[0].rd || out_tag !== exp_q[0].tag) begin
          errors++; $display("FAIL rnd_result cyc=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", cyc, out_data, out_rd, out_tag, exp_q[0].data, exp_q[0].rd, exp_q[0].tag);
        end
      end
      fl = flush;
      cons = out_valid && out_ready && !flush;
      acc = in_valid && in_ready;
      e.data = ref_mul(in_op, in_src1, in_src2); e.rd = in_rd; e.tag = in_tag;
      step();
      if (fl) exp_q.delete();
      else begin
        if (cons && exp_q.size() > 0) f = exp_q.pop_front();
        if (acc) exp_q.push_back(e);
      end
    end
    set_idle(); out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      if (out_valid) begin
        checks++; if (out_data !== exp_q[0].data || out_rd !== exp_q[0].rd || out_tag !== exp_q[0].tag) begin
          errors++; $display("FAIL rnd_drain got=%h/%0d/%0d exp=%h/%0d/%0d", out_data, out_rd, out_tag, exp_q[0].data, exp_q[0].rd, exp_q[0].tag);
        end
        f = exp_q.pop_front();
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d pending exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      set_idle();
      if (cyc < 3) begin
        in_valid = 1'b1; in_op = 2'b11; in_src1 = 32'h1234_5678 + 32'(cyc); in_src2 = 32'hFFFF_0001;
        in_rd = (cyc == 0) ? 5'd3 : (cyc == 1) ? 5'd4 : 5'd6; in_tag = 4'(cyc + 1);
      end
      step();
    end
    set_idle();
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_valid); end
    checks++; if (rd_busy !== 32'h0000_0058) begin errors++; $display("FAIL rstmid_pre_busy got=%h exp=00000058", rd_busy); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_rd !== 5'h0 || out_tag !== 4'h0) begin
      errors++; $display("FAIL rstmid_outputs got=%b/%h/%0d/%0d exp=0/0/0/0", out_valid, out_data, out_rd, out_tag);
    end
    checks++; if (rd_busy !== 32'h0) begin errors++; $display("FAIL rstmid_busy got=%h exp=0", rd_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready_after got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_stages_regression();
    rst = 1'b1; set_idle(); out_ready = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_op = 2'b01; in_src1 = 32'h8000_0000; in_src2 = 32'h8000_0000;
    in_rd = 5'd12; in_tag = 4'hA;
    step();
    set_idle();
    for (int k = 1; k <= 9; k++) begin
      #1;
      checks++; if (s1_out_valid !== (k == 1)) begin errors++; $display("FAIL st1_valid k=%0d got=%b exp=%b", k, s1_out_valid, k == 1); end
      checks++; if (out_valid !== (k == 5)) begin errors++; $display("FAIL st5_valid k=%0d got=%b exp=%b", k, out_valid, k == 5); end
      checks++; if (s8_out_valid !== (k == 8)) begin errors++; $display("FAIL st8_valid k=%0d got=%b exp=%b", k, s8_out_valid, k == 8); end
      if (k == 1) begin
        checks++; if (s1_out_data !== 32'h4000_0000) begin errors++; $display("FAIL st1_data got=%h exp=40000000", s1_out_data); end
      end
      if (k == 5) begin
        checks++; if (out_data !== 32'h4000_0000) begin errors++; $display("FAIL st5_data got=%h exp=40000000", out_data); end
      end
      if (k == 8) begin
        checks++; if (s8_out_data !== 32'h4000_0000) begin errors++; $display("FAIL st8_data got=%h exp=40000000", s8_out_data); end
        checks++; if (s8_out_tag !== 4'hA) begin errors++; $display("FAIL st8_tag got=%h exp=a", s8_out_tag); end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    set_idle();
    test_reset();
    test_basic_ops();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_random();
    test_reset_mid_stream();
    test_stages_regression();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
